sram_uart_transmit_interface: RTL and testbench
===============================================

// Module: sram_uart_transmit_interface
// PURPOSE
//  Reads a block of 16-bit words from external SRAM and streams them out the UART TX pin
//  as bytes: high byte first, then low byte; 8N1 format, LSB first.
//  This is the upload path that sends decoded image data back to the host PC.
//  It mirrors the UART->SRAM receive path and shares the SRAM port through the top-level mux.
// PARAMETERS
//  BAUD_DIV         434   clock cycles per UART bit (50 MHz / 115200)
//  SRAM_RD_LATENCY  2     cycles from SRAM_address valid to SRAM_read_data valid
// PORTS
//  Clock           in   1   system clock, 50 MHz
//  Resetn          in   1   asynchronous, active-low reset
//  Initialize      in   1   synchronous abort/clear, highest priority after reset
//  Enable          in   1   start pulse; ignored unless in S_UT_IDLE
//  Start_address   in   18  first SRAM word address; latched on Enable
//  Word_count      in   18  number of words to send; latched on Enable
//  SRAM_address    out  18  read address
//  SRAM_read_data  in   16  SRAM read data
//  SRAM_we_n       out  1   tied 1; this block never writes
//  UART_TX_O       out  1   serial line, idles high
//  Busy            out  1   high from the cycle after Enable until Done
//  Done            out  1   one-cycle pulse after the final stop bit
// BEHAVIOUR
//  Reset/Initialize values:
//   - SRAM_address=0, SRAM_we_n=1, UART_TX_O=1, Busy=0, Done=0
//   - word counter=0, state=S_UT_IDLE
//   - the serializer is forced idle, so any byte in flight is truncated with the line high
//  State sequence:
//   - IDLE: on Enable, latch the address and count, then go to FETCH. A count of 0 pulses Done the next cycle and sends no bytes.
//   - FETCH: drive SRAM_address. WAIT holds for SRAM_RD_LATENCY cycles, then captures the word into a 16-bit holding register.
//   - SEND_HI: load byte [15:8] into the serializer. WAIT_HI waits until the serializer Busy falls.
//   - SEND_LO: load byte [7:0]. WAIT_LO waits, then decrements the counter.
//   - After WAIT_LO: if count!=0, increment the address and go to FETCH; else go to DONE (Done=1 for 1 cycle, then IDLE).
//  Address rule:
//   - the address saturates at 18'h3FFFF; after sending that word, the transfer ends as if the count were exhausted
//  Serializer frame:
//   - start(0), d0..d7, stop(1); each bit is exactly BAUD_DIV cycles, so a frame is 10*BAUD_DIV cycles
//   - Load is accepted only when not Busy; Busy rises the cycle after Load
//  Throughput:
//   - the gap between consecutive frames is at most 3 + SRAM_RD_LATENCY cycles of idle-high line
//  Simultaneous events:
//   - Initialize overrides Enable in the same cycle
//   - Enable during Busy is ignored, and the latched parameters are unchanged
// CONFIGURATION
//  `UART_TX_CHECKSUM_EN defined:
//   - an 8-bit running sum (mod 256) of every transmitted data byte is kept; reset by Enable
//   - after the last low byte, a CHKSUM state sends the sum as one extra frame before DONE
//   - a count of 0 sends a single 8'h00 checksum frame
//  Not defined:
//   - there is no checksum state or register; the byte stream is exactly 2*Word_count bytes
// STRUCTURE
//  Shared package/state header:
//   - UART_TX_state_type enum S_UT_IDLE, S_UT_FETCH, S_UT_WAIT, S_UT_SEND_HI, S_UT_WAIT_HI,
//     S_UT_SEND_LO, S_UT_WAIT_LO, S_UT_CHKSUM, S_UT_DONE
//   - UART_BAUD_DIV constant, SRAM_ADDR_MAX=18'h3FFFF
//  Sub-module uart_tx_serializer:
//   - inputs Clock, Resetn, Clear, Load, Data[7:0]; outputs Busy, TX
//   - contains the baud counter and the bit counter
// TESTING
//  1. SRAM[100]=16'hA55A, Start_address=100, count=1 -> UART bytes A5, 5A; Done about 20*BAUD_DIV cycles after Enable
//  2. Start_address=76800, count=4 with an incrementing pattern -> 8 bytes in order, addresses 76800..76803 each read once
//  3. Word_count=0 -> Done one cycle after Enable, UART_TX_O stays 1 throughout
//  4. Start_address=18'h3FFFE, count=5 -> exactly 2 words sent, SRAM_address never wraps past 18'h3FFFF
//  5. Initialize asserted mid-frame in word 2 -> UART_TX_O=1 the next cycle, Busy=0, state IDLE, no Done pulse
//  6. With the checksum macro: words 16'h0102, 16'h03FF -> bytes 01 02 03 FF then checksum 8'h05

Source files
------------

// File: rtl/sram_uart_transmit_interface_pkg.sv
// rtl/sram_uart_transmit_interface_pkg.sv - shared states, constants and byte helper for the SRAM-to-UART upload path
package sram_uart_transmit_interface_pkg;

   typedef enum logic [3:0] {
      S_UT_IDLE,
      S_UT_FETCH,
      S_UT_WAIT,
      S_UT_SEND_HI,
      S_UT_WAIT_HI,
      S_UT_SEND_LO,
      S_UT_WAIT_LO,
      S_UT_CHKSUM,
      S_UT_DONE
   } UART_TX_state_type;

   localparam int UART_BAUD_DIV         = 434;
   localparam int UART_SRAM_RD_LATENCY  = 2;
   localparam logic [17:0] SRAM_ADDR_MAX = 18'h3FFFF;

   function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/sram_uart_transmit_interface_if.sv
// rtl/sram_uart_transmit_interface_if.sv - SRAM read port bundle shared through the top-level SRAM mux
interface sram_uart_transmit_interface_if;

   logic [17:0] SRAM_address;
   logic [15:0] SRAM_read_data;
   logic        SRAM_we_n;

   modport master (output SRAM_address, output SRAM_we_n, input SRAM_read_data);
   modport slave  (input SRAM_address, input SRAM_we_n, output SRAM_read_data);

endinterface

// File: rtl/sram_uart_transmit_interface_serializer.sv
// rtl/sram_uart_transmit_interface_serializer.sv - 8N1 LSB-first UART serializer, one bit every BAUD_DIV cycles
module uart_tx_serializer
   import sram_uart_transmit_interface_pkg::*;
#(
   parameter int BAUD_DIV = UART_BAUD_DIV
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Clear,
   input  logic       Load,
   input  logic [7:0] Data,
   output logic       Busy,
   output logic       TX
);

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

   logic [15:0] baud_cnt;
   logic [3:0]  bit_cnt;
   logic [8:0]  shift;
   logic        busy_r;
   logic        tx_r;

   // shift holds {stop, d7..d0}; the start bit is driven directly on load
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '1;
         busy_r   <= 1'b0;
         tx_r     <= 1'b1;
      end else if (Clear) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '1;
         busy_r   <= 1'b0;
         tx_r     <= 1'b1;
      end else if (!busy_r) begin
         if (Load) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= {1'b1, Data};
            busy_r   <= 1'b1;
            tx_r     <= 1'b0;
         end
      end else if (baud_cnt == BAUD_LAST) begin
         baud_cnt <= '0;
         if (bit_cnt == 4'd9) begin
            busy_r <= 1'b0;
            tx_r   <= 1'b1;
         end else begin
            tx_r    <= shift[0];
            shift   <= {1'b1, shift[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         baud_cnt <= baud_cnt + 16'd1;
      end
   end

   assign Busy = busy_r;
   assign TX   = tx_r;

endmodule

// File: rtl/sram_uart_transmit_interface.sv
// rtl/sram_uart_transmit_interface.sv - streams an SRAM word block out the UART, high byte first
// Optional trailing mod-256 checksum frame: UART_TX_CHECKSUM_EN
module sram_uart_transmit_interface
   import sram_uart_transmit_interface_pkg::*;
#(
   parameter int BAUD_DIV        = UART_BAUD_DIV,
   parameter int SRAM_RD_LATENCY = UART_SRAM_RD_LATENCY
) (
   input  logic                            Clock,
   input  logic                            Resetn,
   input  logic                            Initialize,
   input  logic                            Enable,
   input  logic [17:0]                     Start_address,
   input  logic [17:0]                     Word_count,
   sram_uart_transmit_interface_if.master  sram,
   output logic                            UART_TX_O,
   output logic                            Busy,
   output logic                            Done
);

   localparam logic [7:0] WAIT_LAST = 8'(SRAM_RD_LATENCY - 1);

`ifdef UART_TX_CHECKSUM_EN
   localparam UART_TX_state_type END_STATE = S_UT_CHKSUM;
`else
   localparam UART_TX_state_type END_STATE = S_UT_DONE;
`endif

   UART_TX_state_type state, next_state;

   logic [17:0] address;
   logic [17:0] word_counter;
   logic [15:0] hold_word;
   logic [7:0]  wait_cnt;
   logic        last_word;
   logic        ser_load;
   logic [7:0]  ser_data;
   logic        ser_busy;

`ifdef UART_TX_CHECKSUM_EN
   logic [7:0]  checksum;
   logic        chk_sent;
`endif

   // saturation at the top of SRAM ends the block just like an exhausted count
   assign last_word = (word_counter == 18'd1) || (address == SRAM_ADDR_MAX);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= S_UT_IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      ser_load   = 1'b0;
      ser_data   = 8'h00;
      unique case (state)
         S_UT_IDLE:    if (Enable) next_state = (Word_count == 18'd0) ? END_STATE : S_UT_FETCH;
         S_UT_FETCH:   next_state = S_UT_WAIT;
         S_UT_WAIT:    if (wait_cnt == WAIT_LAST) next_state = S_UT_SEND_HI;
         S_UT_SEND_HI: begin
            ser_load   = 1'b1;
            ser_data   = byte_sel(hold_word, 1'b1);
            next_state = S_UT_WAIT_HI;
         end
         S_UT_WAIT_HI: if (!ser_busy) next_state = S_UT_SEND_LO;
         S_UT_SEND_LO: begin
            ser_load   = 1'b1;
            ser_data   = byte_sel(hold_word, 1'b0);
            next_state = S_UT_WAIT_LO;
         end
         S_UT_WAIT_LO: if (!ser_busy) next_state = last_word ? END_STATE : S_UT_FETCH;
`ifdef UART_TX_CHECKSUM_EN
         S_UT_CHKSUM: begin
            if (!ser_busy) begin
               if (!chk_sent) begin
                  ser_load = 1'b1;
                  ser_data = checksum;
               end else begin
                  next_state = S_UT_DONE;
               end
            end
         end
`else
         S_UT_CHKSUM:  next_state = S_UT_DONE;
`endif
         S_UT_DONE:    next_state = S_UT_IDLE;
         default:      next_state = S_UT_IDLE;
      endcase
      if (Initialize) begin
         next_state = S_UT_IDLE;
         ser_load   = 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         address      <= '0;
         word_counter <= '0;
         hold_word    <= '0;
         wait_cnt     <= '0;
      end else if (Initialize) begin
         address      <= '0;
         word_counter <= '0;
         hold_word    <= '0;
         wait_cnt     <= '0;
      end else begin
         case (state)
            S_UT_IDLE: begin
               if (Enable) begin
                  address      <= Start_address;
                  word_counter <= Word_count;
               end
            end
            S_UT_FETCH: wait_cnt <= '0;
            S_UT_WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (wait_cnt == WAIT_LAST) hold_word <= sram.SRAM_read_data;
            end
            S_UT_WAIT_LO: begin
               if (!ser_busy) begin
                  word_counter <= word_counter - 18'd1;
                  if (!last_word) address <= address + 18'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef UART_TX_CHECKSUM_EN
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         checksum <= '0;
         chk_sent <= 1'b0;
      end else if (Initialize) begin
         checksum <= '0;
         chk_sent <= 1'b0;
      end else begin
         if (state == S_UT_IDLE && Enable)
            checksum <= '0;
         else if (ser_load && state != S_UT_CHKSUM)
            checksum <= checksum + ser_data;
         chk_sent <= (state == S_UT_CHKSUM) ? (chk_sent | ser_load) : 1'b0;
      end
   end
`endif

   uart_tx_serializer #(.BAUD_DIV(BAUD_DIV)) u_serializer (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Clear  (Initialize),
      .Load   (ser_load),
      .Data   (ser_data),
      .Busy   (ser_busy),
      .TX     (UART_TX_O)
   );

   assign sram.SRAM_address = address;
   assign sram.SRAM_we_n    = 1'b1;
   assign Busy = (state != S_UT_IDLE) && (state != S_UT_DONE);
   assign Done = (state == S_UT_DONE);

endmodule

// File: tb/tb_sram_uart_transmit_interface.sv
// tb/tb_sram_uart_transmit_interface.sv - scoreboard bench: SRAM model, UART decoder, per-block reference model
module tb_sram_uart_transmit_interface;
   import sram_uart_transmit_interface_pkg::*;

   localparam int DIV = 8;
   localparam int LAT = 2;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b1;
   logic        Initialize = 1'b0;
   logic        Enable = 1'b0;
   logic [17:0] Start_address = '0;
   logic [17:0] Word_count = '0;
   logic        UART_TX_O, Busy, Done;

   sram_uart_transmit_interface_if sif ();

   sram_uart_transmit_interface #(.BAUD_DIV(DIV), .SRAM_RD_LATENCY(LAT)) dut (
      .Clock         (Clock),
      .Resetn        (Resetn),
      .Initialize    (Initialize),
      .Enable        (Enable),
      .Start_address (Start_address),
      .Word_count    (Word_count),
      .sram          (sif),
      .UART_TX_O     (UART_TX_O),
      .Busy          (Busy),
      .Done          (Done)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   logic [7:0]  exp_q [$];
   logic [17:0] addr_log [$];
   logic [17:0] addr_prev = '0;
   bit          discard = 1'b0;
   int          tx_low = 0;
   logic [15:0] mem [0:262143];
   logic [15:0] pipe1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // two-cycle read latency SRAM
   always @(posedge Clock) begin
      pipe1 <= mem[sif.SRAM_address];
      sif.SRAM_read_data <= pipe1;
   end

   always @(negedge Clock) begin
      if (sif.SRAM_address !== addr_prev) begin
         addr_log.push_back(sif.SRAM_address);
         addr_prev = sif.SRAM_address;
      end
      if (UART_TX_O === 1'b0) tx_low++;
   end

   // UART decoder: samples each bit at its centre and scores against exp_q
   initial begin : uart_monitor
      logic [7:0] b;
      logic st, sp;
      forever begin
         do @(negedge Clock); while (UART_TX_O !== 1'b1);
         do @(negedge Clock); while (UART_TX_O !== 1'b0);
         repeat (DIV / 2) @(negedge Clock);
         st = UART_TX_O;
         b = '0;
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge Clock);
            b = {UART_TX_O, b[7:1]};
         end
         repeat (DIV) @(negedge Clock);
         sp = UART_TX_O;
         if (!discard) begin
            check("rx_start_bit", 32'(st), 32'd0);
            check("rx_stop_bit", 32'(sp), 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rx_unexpected_byte: actual=%0h required=none", b);
            end else begin
               check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic run_xfer(input string tag, input logic [17:0] start, input logic [17:0] count,
                           input bit fill, input bit inject);
      logic [17:0] a;
      logic [7:0]  sum;
      logic [17:0] exp_addrs [$];
      int nbytes, cycles, limit, low0;
      bit busy_drop, dur_ok;
      a = start;
      sum = '0;
      nbytes = 0;
      for (int i = 0; i < int'(count); i++) begin
         if (fill) mem[a] = 16'($urandom);
         exp_q.push_back(mem[a][15:8]);
         exp_q.push_back(mem[a][7:0]);
         sum = sum + mem[a][15:8] + mem[a][7:0];
         nbytes += 2;
         exp_addrs.push_back(a);
         if (a == SRAM_ADDR_MAX) break;
         a = a + 18'd1;
      end
`ifdef UART_TX_CHECKSUM_EN
      exp_q.push_back(sum);
      nbytes++;
`endif
      if (count == 18'd0) exp_addrs.push_back(start);
      if (exp_addrs[0] == addr_prev) void'(exp_addrs.pop_front());
      addr_log.delete();

      @(negedge Clock);
      Start_address = start;
      Word_count = count;
      Enable = 1'b1;
      low0 = tx_low;
      @(negedge Clock);
      Enable = 1'b0;
      cycles = 1;
      if (nbytes == 0) check({tag, "_done_next_cycle"}, 32'(Done), 32'd1);
      else             check({tag, "_busy_after_enable"}, 32'(Busy), 32'd1);

      limit = nbytes * (10 * DIV + 3 + LAT) + 20;
      busy_drop = 1'b0;
      while (Done !== 1'b1 && cycles < limit) begin
         if (inject && cycles == 3) begin
            Start_address = ~start;
            Word_count = 18'd7;
            Enable = 1'b1;
         end else begin
            Enable = 1'b0;
         end
         @(negedge Clock);
         cycles++;
         if (Done !== 1'b1 && Busy !== 1'b1) busy_drop = 1'b1;
      end
      Enable = 1'b0;
      check({tag, "_done_seen"}, 32'(Done), 32'd1);
      dur_ok = (cycles >= nbytes * 10 * DIV) && (cycles <= nbytes * (10 * DIV + 3 + LAT) + 4);
      check({tag, "_duration_in_range"}, 32'(dur_ok), 32'd1);
      check({tag, "_busy_held"}, 32'(busy_drop), 32'd0);
      @(negedge Clock);
      check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
      check({tag, "_busy_after_done"}, 32'(Busy), 32'd0);
      check({tag, "_bytes_outstanding"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_addr_count"}, 32'(addr_log.size()), 32'(exp_addrs.size()));
      for (int i = 0; i < exp_addrs.size() && i < addr_log.size(); i++)
         check({tag, "_addr_seq"}, 32'(addr_log[i]), 32'(exp_addrs[i]));
      if (nbytes == 0) begin
         repeat (20) @(negedge Clock);
         check({tag, "_line_idle"}, 32'(tx_low - low0), 32'd0);
      end
      exp_q.delete();
   endtask

   initial begin : stimulus
      int guard, low0;
      bit done_seen;
      #1 Resetn = 1'b0;
      repeat (3) @(negedge Clock);
      check("reset_tx", 32'(UART_TX_O), 32'd1);
      check("reset_busy", 32'(Busy), 32'd0);
      check("reset_done", 32'(Done), 32'd0);
      check("reset_addr", 32'(sif.SRAM_address), 32'd0);
      check("reset_we_n", 32'(sif.SRAM_we_n), 32'd1);
      Resetn = 1'b1;
      repeat (2) @(negedge Clock);

      mem[100] = 16'hA55A;
      run_xfer("single_word", 18'd100, 18'd1, 1'b0, 1'b0);

      for (int i = 0; i < 4; i++) mem[76800 + i] = 16'h1000 + 16'(i * 16'h0111);
      run_xfer("incr_block", 18'd76800, 18'd4, 1'b0, 1'b1);

      run_xfer("zero_count", 18'd1234, 18'd0, 1'b0, 1'b0);

      run_xfer("saturate", 18'h3FFFE, 18'd5, 1'b1, 1'b0);

      for (int i = 0; i < 4; i++)
         run_xfer("random", 18'($urandom_range(0, 32'h3FF00)), 18'($urandom_range(1, 3)), 1'b1, i[0]);

`ifdef UART_TX_CHECKSUM_EN
      mem[200] = 16'h0102;
      mem[201] = 16'h03FF;
      run_xfer("checksum", 18'd200, 18'd2, 1'b0, 1'b0);
`endif

      // Initialize and Enable in the same cycle: Initialize wins
      @(negedge Clock);
      Start_address = 18'd300;
      Word_count = 18'd1;
      Enable = 1'b1;
      Initialize = 1'b1;
      low0 = tx_low;
      @(negedge Clock);
      Enable = 1'b0;
      Initialize = 1'b0;
      check("init_over_enable_busy", 32'(Busy), 32'd0);
      check("init_over_enable_addr", 32'(sif.SRAM_address), 32'd0);
      repeat (3 * DIV) @(negedge Clock);
      check("init_over_enable_line", 32'(tx_low - low0), 32'd0);

      // Initialize part-way through the second word's high-byte frame
      for (int i = 0; i < 3; i++) begin
         mem[500 + i] = 16'($urandom);
         exp_q.push_back(mem[500 + i][15:8]);
         exp_q.push_back(mem[500 + i][7:0]);
      end
      @(negedge Clock);
      Start_address = 18'd500;
      Word_count = 18'd3;
      Enable = 1'b1;
      @(negedge Clock);
      Enable = 1'b0;
      guard = 0;
      while (exp_q.size() > 4 && guard < 4 * (10 * DIV + 3 + LAT)) begin
         @(negedge Clock);
         guard++;
      end
      check("abort_first_word_sent", 32'(exp_q.size()), 32'd4);
      repeat (3 * DIV) @(negedge Clock);
      discard = 1'b1;
      Initialize = 1'b1;
      @(negedge Clock);
      Initialize = 1'b0;
      check("abort_tx_high", 32'(UART_TX_O), 32'd1);
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_addr", 32'(sif.SRAM_address), 32'd0);
      low0 = tx_low;
      done_seen = 1'b0;
      repeat (15 * DIV) begin
         @(negedge Clock);
         if (Done === 1'b1) done_seen = 1'b1;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_line_idle", 32'(tx_low - low0), 32'd0);
      exp_q.delete();
      discard = 1'b0;

      mem[100] = 16'h3C96;
      run_xfer("after_abort", 18'd100, 18'd1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
